// File: rtl/p_u2b_pipe.sv
// p_u2b_pipe: two-stage valid/ready unary/thermometer admission and binary count, with saturating stats
module p_u2b_pipe #(
  parameter int W = 16,
  parameter int P_ADMIT_COMPLIMENT_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vld,
  output logic                     o_rdy,
  input  logic [W-1:0]             i_x,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [$clog2(W+1)-1:0]   o_cnt,
  output logic                     o_is_unary,
  output logic                     o_is_compl,
  input  logic                     i_stat_clr,
  output logic [CNT_W-1:0]         o_acc_cnt,
  output logic [CNT_W-1:0]         o_rej_cnt
);
  localparam int CW = $clog2(W+1);
  localparam bit EN = P_ADMIT_COMPLIMENT_EN != 0;
  logic           s1_vld;
  logic [W-1:0]   s1_x;
  logic [W-1:0]   xn;
  logic [W-1:0]   inc;
  logic [CW-1:0]  pc;
  logic           m;
  logic           adm;
  logic           s2_adv;
  logic           xfer;
  assign s2_adv = ~o_vld | i_rdy;
  assign o_rdy  = ~s1_vld | s2_adv;
  assign xfer   = o_vld & i_rdy;
  always_comb begin
    m   = s1_x[W-1];
    xn  = (EN && m) ? ~s1_x : s1_x;
    inc = xn + 1'b1;
    adm = (inc != '0) && ((inc & (inc - 1'b1)) == '0) && (EN || !m);
    pc  = '0;
    for (int i = 0; i < W; i++) pc = pc + CW'(xn[i]);
  end
  always_ff @(posedge clk) begin
    if (i_vld && o_rdy) s1_x <= i_x;
    if (rst) begin
      s1_vld     <= 1'b0;
      o_vld      <= 1'b0;
      o_cnt      <= '0;
      o_is_unary <= 1'b0;
      o_is_compl <= 1'b0;
      o_acc_cnt  <= '0;
      o_rej_cnt  <= '0;
    end else begin
      if (o_rdy) s1_vld <= i_vld;
      if (s2_adv) o_vld <= s1_vld;
      if (s2_adv && s1_vld) begin
        o_cnt      <= adm ? pc : '0;
        o_is_unary <= adm;
        o_is_compl <= EN && m;
      end
      if (i_stat_clr) begin
        o_acc_cnt <= '0;
        o_rej_cnt <= '0;
      end else if (xfer) begin
        o_acc_cnt <= o_acc_cnt + CNT_W'(o_is_unary && o_acc_cnt != '1);
        o_rej_cnt <= o_rej_cnt + CNT_W'(!o_is_unary && o_rej_cnt != '1);
      end
    end
  end
endmodule

// File: tb/tb_p_u2b_pipe.sv
// tb_p_u2b_pipe: directed and randomized checks of p_u2b_pipe against a behavioural model
module tb_p_u2b_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [3:0]  vld, rdy, ordy, ovld, unary, compl, clr;
  logic [15:0] x [4];
  logic [4:0]  cnt [4];
  logic [15:0] acc [3];
  logic [15:0] rej [3];
  logic [1:0]  acc3, rej3;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    p_u2b_pipe #(.W(16), .P_ADMIT_COMPLIMENT_EN(g != 2), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .i_vld(vld[g]), .o_rdy(ordy[g]), .i_x(x[g]),
      .o_vld(ovld[g]), .i_rdy(rdy[g]), .o_cnt(cnt[g]), .o_is_unary(unary[g]),
      .o_is_compl(compl[g]), .i_stat_clr(clr[g]), .o_acc_cnt(acc[g]), .o_rej_cnt(rej[g]));
  end
  p_u2b_pipe #(.W(16), .P_ADMIT_COMPLIMENT_EN(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .i_vld(vld[3]), .o_rdy(ordy[3]), .i_x(x[3]),
    .o_vld(ovld[3]), .i_rdy(rdy[3]), .o_cnt(cnt[3]), .o_is_unary(unary[3]),
    .o_is_compl(compl[3]), .i_stat_clr(clr[3]), .o_acc_cnt(acc3), .o_rej_cnt(rej3));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] res(input int l);
    return {compl[l], unary[l], cnt[l]};
  endfunction

  // {compl, unary, cnt}: complement words are ones followed by zeros, normal words are zeros followed by ones
  function automatic logic [6:0] model(input logic [15:0] v, input bit en);
    logic [15:0] f;
    int t;
    bit a;
    if (en && v[15]) begin
      t = 0;
      while (t < 15 && !v[t]) t++;
      f = 16'hFFFF << t;
      a = (v == f);
      return {1'b1, a, a ? 5'(t) : 5'd0};
    end
    t = $countones(v);
    f = 16'((32'd1 << t) - 32'd1);
    a = !v[15] && (v == f);
    return {1'b0, a, a ? 5'(t) : 5'd0};
  endfunction

  initial begin
    logic [15:0] w [3];
    logic [6:0]  q [$];
    logic [6:0]  q0 [$];
    logic [6:0]  q1 [$];
    logic [6:0]  e;
    int k, n, cyc_n;
    int idx [2];
    int nacc [2];
    int nrej [2];
    vld = '0; rdy = '0; clr = '0;
    for (int l = 0; l < 4; l++) x[l] = '0;
    repeat (2) cyc;
    rst = 1'b0;
    for (int l = 0; l < 4; l++) begin
      chk("rst_vld", 32'(ovld[l]), 32'd0);
      chk("rst_rdy", 32'(ordy[l]), 32'd1);
      chk("rst_out", 32'(res(l)), 32'd0);
    end
    for (int l = 0; l < 3; l++) chk("rst_stats", {acc[l], rej[l]}, 32'd0);
    chk("rst_stats_sat", 32'({acc3, rej3}), 32'd0);

    rdy[0] = 1'b1; vld[0] = 1'b1; x[0] = 16'h0007;
    cyc;
    chk("t1_latency", 32'(ovld[0]), 32'd0);
    x[0] = 16'hFFF0;
    cyc;
    chk("t1_w0", 32'({ovld[0], res(0)}), 32'({1'b1, 1'b0, 1'b1, 5'd3}));
    x[0] = 16'h0105;
    cyc;
    chk("t1_w1", 32'({ovld[0], res(0)}), 32'({1'b1, 1'b1, 1'b1, 5'd4}));
    vld[0] = 1'b0;
    cyc;
    chk("t1_w2", 32'({ovld[0], res(0)}), 32'({1'b1, 1'b0, 1'b0, 5'd0}));
    cyc;
    chk("t1_idle", 32'(ovld[0]), 32'd0);
    chk("t1_acc", 32'(acc[0]), 32'd2);
    chk("t1_rej", 32'(rej[0]), 32'd1);

    rdy[2] = 1'b1; vld[2] = 1'b1; x[2] = 16'hFFFE;
    cyc;
    x[2] = 16'h0000;
    cyc;
    chk("t2_fffe", 32'({ovld[2], res(2)}), 32'({1'b1, 7'd0}));
    vld[2] = 1'b0;
    cyc;
    chk("t2_zero", 32'({ovld[2], res(2)}), 32'({1'b1, 1'b0, 1'b1, 5'd0}));
    cyc;
    chk("t2_stats", {acc[2], rej[2]}, {16'd1, 16'd1});

    w[0] = 16'h0003; w[1] = 16'hFF00; w[2] = 16'h0001;
    rdy[0] = 1'b0; vld[0] = 1'b1; x[0] = w[0]; k = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (ordy[0]) begin
        q.push_back(model(x[0], 1'b1));
        k++;
      end
      cyc;
      x[0] = (k < 3) ? w[k] : 16'h1234;
      if (i >= 1) chk("t3_hold", 32'({ovld[0], res(0)}), 32'({1'b1, model(w[0], 1'b1)}));
    end
    chk("t3_accepted", k, 2);
    chk("t3_rdy_low", 32'(ordy[0]), 32'd0);
    vld[0] = 1'b0; rdy[0] = 1'b1; n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ovld[0]) begin
        if (q.size() == 0) chk("t3_dup", 32'(ovld[0]), 32'd0);
        else begin
          e = q.pop_front();
          chk("t3_order", 32'(res(0)), 32'(e));
          n++;
        end
      end
      cyc;
    end
    chk("t3_drained", n, 2);

    rdy[3] = 1'b1; vld[3] = 1'b1; x[3] = 16'h0001;
    for (int i = 0; i < 7; i++) begin
      cyc;
      if (i == 4) vld[3] = 1'b0;
      if (i >= 2) chk("t4_sat", 32'(acc3), (i - 1 > 3) ? 32'd3 : 32'(i - 1));
    end
    chk("t4_rej", 32'(rej3), 32'd0);
    vld[3] = 1'b1;
    cyc;
    vld[3] = 1'b0;
    cyc;
    chk("t4_pending", 32'(ovld[3]), 32'd1);
    clr[3] = 1'b1;
    cyc;
    clr[3] = 1'b0;
    chk("t4_clr", 32'({ovld[3], acc3, rej3}), 32'd0);
    cyc;
    chk("t4_clr_hold", 32'(acc3), 32'd0);

    rdy[0] = 1'b0; vld[0] = 1'b1; x[0] = 16'h0003;
    repeat (3) cyc;
    chk("t5_full", 32'({ordy[0], ovld[0]}), 32'd1);
    rst = 1'b1; vld[0] = 1'b0;
    cyc;
    chk("t5_rst_vld", 32'(ovld[0]), 32'd0);
    chk("t5_rst_stats", {acc[0], rej[0]}, 32'd0);
    chk("t5_rst_stats2", {acc[2], rej[2]}, 32'd0);
    rst = 1'b0;
    #1;
    chk("t5_rdy", 32'(ordy[0]), 32'd1);
    cyc;
    chk("t5_no_ghost", 32'({ordy[0], ovld[0]}), 32'd2);

    idx = '{0, 0}; nacc = '{0, 0}; nrej = '{0, 0}; cyc_n = 0;
    while ((idx[0] < 32768 || idx[1] < 32768 || q0.size() != 0 || q1.size() != 0) && cyc_n < 60000) begin
      for (int l = 0; l < 2; l++) begin
        rdy[l] = ($urandom_range(9) != 0);
        vld[l] = (idx[l] < 32768) && ($urandom_range(9) != 0);
        x[l] = vld[l] ? 16'(l * 32768 + idx[l]) : 16'($urandom);
      end
      #1;
      for (int l = 0; l < 2; l++) begin
        if (ovld[l] && rdy[l]) begin
          if ((l == 0 ? q0.size() : q1.size()) == 0) chk("rand_extra", 32'(ovld[l]), 32'd0);
          else begin
            e = (l == 0) ? q0.pop_front() : q1.pop_front();
            chk("rand", 32'(res(l)), 32'(e));
            if (e[5]) nacc[l]++;
            else nrej[l]++;
          end
        end
        if (vld[l] && ordy[l]) begin
          if (l == 0) q0.push_back(model(x[l], 1'b1));
          else q1.push_back(model(x[l], 1'b1));
          idx[l]++;
        end
      end
      cyc;
      cyc_n++;
    end
    vld[1:0] = 2'b00;
    chk("rand_budget", 32'(cyc_n < 60000), 32'd1);
    chk("rand_all_words", idx[0] + idx[1], 65536);
    for (int l = 0; l < 2; l++) begin
      chk("rand_acc", 32'(acc[l]), 32'(nacc[l]));
      chk("rand_rej", 32'(rej[l]), 32'(nrej[l]));
    end
    chk("rand_acc_total", 32'(acc[0]) + 32'(acc[1]), 32'd32);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
